// File: rtl/alu_wb_skid_stage_if.sv
// Handshake bundle between the ALU output, the writeback skid stage and the register-file write port.
// The slave modport is the stage's view; the master modport is the view of whatever drives and drains it.
interface alu_wb_skid_stage_if #(
  parameter int WIDTH   = 32,
  parameter int RD_BITS = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_y;
  logic               in_carry;
  logic               in_ovf;
  logic               in_set;
  logic [RD_BITS-1:0] in_rd;
  logic               in_we;

  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_y;
  logic [3:0]         out_flags;
  logic [RD_BITS-1:0] out_rd;
  logic               out_we;

  modport slave (
    input  in_valid, in_y, in_carry, in_ovf, in_set, in_rd, in_we, out_ready,
    output in_ready, out_valid, out_y, out_flags, out_rd, out_we
  );

  modport master (
    output in_valid, in_y, in_carry, in_ovf, in_set, in_rd, in_we, out_ready,
    input  in_ready, out_valid, out_y, out_flags, out_rd, out_we
  );
endinterface

// File: rtl/alu_wb_skid_stage.sv
// Execute-to-writeback stage: 2-entry skid buffer for ALU result, flags and destination tag, plus sticky overflow.
// Optional forwarding outputs byp_valid/byp_rd/byp_y are built only when ALU_WB_BYPASS_EN is defined.
module alu_wb_skid_stage #(
  parameter int WIDTH   = 32,
  parameter int RD_BITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  alu_wb_skid_stage_if.slave   bus,
  input  logic                 ovf_clear,
  output logic                 ovf_sticky
`ifdef ALU_WB_BYPASS_EN
  ,
  output logic                 byp_valid,
  output logic [RD_BITS-1:0]   byp_rd,
  output logic [WIDTH-1:0]     byp_y
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  // flags are packed {zero, set, ovf, carry}; we already has the x0 suppression folded in
  typedef struct packed {
    logic [WIDTH-1:0]   y;
    logic [3:0]         flags;
    logic [RD_BITS-1:0] rd;
    logic               we;
  } bundle_t;

  state_t  state_q, state_d;
  bundle_t main_q, main_d;
  bundle_t skid_q, skid_d;
  bundle_t in_bundle;
  logic    in_ready_q;
  logic    xfer_in;
  logic    xfer_out;

  assign xfer_in  = bus.in_valid & in_ready_q;
  assign xfer_out = (state_q != EMPTY) & bus.out_ready;

  always_comb begin
    in_bundle.y     = bus.in_y;
    in_bundle.flags = {(bus.in_y == '0), bus.in_set, bus.in_ovf, bus.in_carry};
    in_bundle.rd    = bus.in_rd;
    in_bundle.we    = bus.in_we & (bus.in_rd != '0);
  end

  // NOTE: every always_comb output gets its hold value first, so no branch can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (xfer_in) begin
          main_d  = in_bundle;
          state_d = ONE;
        end
      end
      ONE: begin
        if (xfer_in && xfer_out) begin
          main_d = in_bundle;
        end else if (xfer_in) begin
          skid_d  = in_bundle;
          state_d = FULL;
        end else if (xfer_out) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (xfer_out) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values regardless of block order.
  // NOTE: the skid entry is reset along with main; it is only two words and keeps held bundles from resurfacing.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != FULL);
    end
  end

  // a set in the same cycle as a clear wins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovf_sticky <= 1'b0;
    end else if (xfer_in && bus.in_ovf) begin
      ovf_sticky <= 1'b1;
    end else if (ovf_clear) begin
      ovf_sticky <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = (state_q != EMPTY);
  assign bus.out_y     = main_q.y;
  assign bus.out_flags = main_q.flags;
  assign bus.out_rd    = main_q.rd;
  assign bus.out_we    = main_q.we;

`ifdef ALU_WB_BYPASS_EN
  // the bundle still on the ALU outputs is younger than anything buffered, so it takes priority
  always_comb begin
    byp_valid = 1'b0;
    byp_rd    = main_q.rd;
    byp_y     = main_q.y;
    if (bus.in_valid && bus.in_we && (bus.in_rd != '0)) begin
      byp_valid = 1'b1;
      byp_rd    = bus.in_rd;
      byp_y     = bus.in_y;
    end else begin
      byp_valid = (state_q != EMPTY) & main_q.we;
    end
  end
`endif

endmodule

// File: tb/tb_alu_wb_skid_stage.sv
// Directed and randomized bench for alu_wb_skid_stage: a scoreboard queue of expected bundles is filled on
// each input transfer and drained on each output transfer; inputs change and outputs are sampled on the falling edge.
module tb_alu_wb_skid_stage;
  localparam int WIDTH   = 32;
  localparam int RD_BITS = 5;

  typedef struct packed {
    logic [WIDTH-1:0]   y;
    logic [3:0]         flags;
    logic [RD_BITS-1:0] rd;
    logic               we;
  } exp_t;

  logic clk;
  logic reset;
  logic ovf_clear;
  logic ovf_sticky;

  alu_wb_skid_stage_if #(.WIDTH(WIDTH), .RD_BITS(RD_BITS)) bus ();

  alu_wb_skid_stage #(.WIDTH(WIDTH), .RD_BITS(RD_BITS)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .ovf_clear  (ovf_clear),
    .ovf_sticky (ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] y, input logic carry, input logic ovf,
                       input logic set, input logic [RD_BITS-1:0] rd, input logic we);
    bus.in_valid = v;
    bus.in_y     = y;
    bus.in_carry = carry;
    bus.in_ovf   = ovf;
    bus.in_set   = set;
    bus.in_rd    = rd;
    bus.in_we    = we;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  // Called at a falling edge with inputs already driven: score the transfers the next rising edge will perform.
  task automatic tick(output bit pushed);
    exp_t e;
    exp_t got;
    pushed = 1'b0;
    if (bus.out_valid && bus.out_ready) begin
      check("sb_not_empty", 64'(sb_q.size() != 0), 64'd1);
      if (sb_q.size() != 0) begin
        e   = sb_q.pop_front();
        got = {bus.out_y, bus.out_flags, bus.out_rd, bus.out_we};
        check("sb_bundle", 64'(got), 64'(e));
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      e.y     = bus.in_y;
      e.flags = {(bus.in_y == 0), bus.in_set, bus.in_ovf, bus.in_carry};
      e.rd    = bus.in_rd;
      e.we    = bus.in_we && (bus.in_rd != 0);
      sb_q.push_back(e);
      pushed = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    bit p;
    int accepted;
    reset         = 1'b1;
    ovf_clear     = 1'b0;
    bus.out_ready = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // reset state
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_bus", 64'({bus.out_y, bus.out_flags, bus.out_rd, bus.out_we}), 64'd0);
    check("rst_sticky", 64'(ovf_sticky), 64'd0);

    // zero result: visible one cycle after transfer with zero flag set
    bus.out_ready = 1'b1;
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 5'd3, 1'b1);
    tick(p);
    idle();
    check("zero_out_valid", 64'(bus.out_valid), 64'd1);
    check("zero_flags", 64'(bus.out_flags), 64'b1000);
    check("zero_out_we", 64'(bus.out_we), 64'd1);
    tick(p);
    check("zero_drained", 64'(bus.out_valid), 64'd0);

    // fill both entries under stall, then release
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1);
    tick(p);
    drive(1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 5'd2, 1'b1);
    tick(p);
    check("full_in_ready", 64'(bus.in_ready), 64'd0);
    check("full_out_y", 64'(bus.out_y), 64'h11);
    drive(1'b1, 32'h33, 1'b1, 1'b0, 1'b0, 5'd4, 1'b1);
    tick(p);
    check("full_ignored_push", 64'(p), 64'd0);
    check("full_hold_y", 64'(bus.out_y), 64'h11);
    idle();
    bus.out_ready = 1'b1;
    tick(p);
    check("release_out_y", 64'(bus.out_y), 64'h22);
    check("release_in_ready", 64'(bus.in_ready), 64'd1);
    tick(p);
    check("release_empty", 64'(bus.out_valid), 64'd0);

    // x0 destination: delivered, write suppressed
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h5, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1);
    tick(p);
    idle();
    check("x0_out_valid", 64'(bus.out_valid), 64'd1);
    check("x0_out_we", 64'(bus.out_we), 64'd0);
    check("x0_out_y", 64'(bus.out_y), 64'h5);
    bus.out_ready = 1'b1;
    tick(p);

    // sticky overflow: set, set beats clear, clear alone
    drive(1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 5'd7, 1'b1);
    tick(p);
    check("ovf_set", 64'(ovf_sticky), 64'd1);
    drive(1'b1, 32'h8000_0001, 1'b0, 1'b1, 1'b1, 5'd8, 1'b1);
    ovf_clear = 1'b1;
    tick(p);
    check("ovf_set_beats_clear", 64'(ovf_sticky), 64'd1);
    idle();
    tick(p);
    check("ovf_clear", 64'(ovf_sticky), 64'd0);
    ovf_clear = 1'b0;
    tick(p);

    // full throughput with out_ready held high
    accepted = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i * 3 + 1), 1'(i), 1'b0, 1'b0, 5'(i + 9), 1'b1);
      tick(p);
      if (p) accepted++;
    end
    check("throughput", 64'(accepted), 64'd8);
    idle();
    tick(p);

    // random streaming with random backpressure
    accepted = 0;
    for (int c = 0; c < 2000 && accepted < 100; c++) begin
      drive(1'($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0) ? 32'h0 : 32'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom),
            5'($urandom_range(0, 31)), 1'($urandom));
      bus.out_ready = 1'($urandom);
      tick(p);
      if (p) accepted++;
    end
    check("stream_accepted", 64'(accepted), 64'd100);
    idle();
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10 && sb_q.size() != 0; c++) tick(p);
    check("stream_sb_drained", 64'(sb_q.size()), 64'd0);
    check("stream_out_idle", 64'(bus.out_valid), 64'd0);

    // asynchronous reset while FULL discards held bundles
    bus.out_ready = 1'b0;
    drive(1'b1, 32'hAA, 1'b0, 1'b1, 1'b0, 5'd10, 1'b1);
    tick(p);
    drive(1'b1, 32'hBB, 1'b0, 1'b0, 1'b0, 5'd11, 1'b1);
    tick(p);
    idle();
    check("pre_rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("pre_rst_sticky", 64'(ovf_sticky), 64'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("async_rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("async_rst_sticky", 64'(ovf_sticky), 64'd0);
    check("async_rst_out_y", 64'(bus.out_y), 64'd0);
    sb_q.delete();
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    repeat (4) tick(p);
    check("post_rst_no_ghost", 64'(bus.out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
